seq_majority_voter: RTL and testbench

SEQ_MAJORITY_VOTER -- requirements
Module: seq_majority_voter

---
 rtl/seq_majority_voter.sv | 141 ++++++++++++++
 tb/tb_seq_majority_voter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_majority_voter.sv
// seq_majority_voter: bitwise strict-majority voter across N redundant channels.
// It has a one-entry registered output with valid/ready handshake.
// Per-channel saturating disagreement counters raise sticky fault flags.
// A faulted channel drops out of later votes until clr_fault or reset.
module seq_majority_voter #(
  parameter int N         = 9,
  parameter int W         = 16,
  parameter int FAULT_LIM = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_bus,
  input  logic [N-1:0]   chan_en,
  input  logic           clr_fault,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   y,
  output logic [N-1:0]   disagree,
  output logic [N-1:0]   fault,
  output logic           no_quorum
);

  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  active;
  logic [CW-1:0] act_cnt;
  logic [CW-1:0] bit_cnt;
  logic [W-1:0]  vote;
  logic [N-1:0]  diff;
  logic          xfer;

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  y_q, y_d;
  logic [N-1:0]  disagree_q, disagree_d;
  logic          no_quorum_q, no_quorum_d;
  logic [N-1:0]  fault_q, fault_d;
  logic [3:0]    cnt_q [N];
  logic [3:0]    cnt_d [N];

  assign in_ready  = !out_valid_q || out_ready;
  assign xfer      = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign disagree  = disagree_q;
  assign no_quorum = no_quorum_q;
  assign fault     = fault_q;

  // Vote datapath: active set, per-bit strict majority, per-channel disagreement.
  always_comb begin
    active  = chan_en & ~fault_q;
    act_cnt = '0;
    bit_cnt = '0;
    vote    = '0;
    diff    = '0;
    for (int k = 0; k < N; k++) begin
      act_cnt = act_cnt + CW'(active[k]);
    end
    for (int i = 0; i < W; i++) begin
      bit_cnt = '0;
      for (int k = 0; k < N; k++) begin
        bit_cnt = bit_cnt + CW'(active[k] & in_bus[k*W+i]);
      end
      // bit_cnt >= floor(A/2)+1 is the same as bit_cnt > floor(A/2); A=0 yields 0.
      vote[i] = (bit_cnt > (act_cnt >> 1));
    end
    for (int k = 0; k < N; k++) begin
      diff[k] = active[k] && (in_bus[k*W +: W] != vote);
    end
  end

  // Output register next state: load on transfer, drain on out_ready.
  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    disagree_d  = disagree_q;
    no_quorum_d = no_quorum_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      y_d         = vote;
      disagree_d  = diff;
      no_quorum_d = (act_cnt == '0);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Fault tracking next state: a clear wins over counter updates from a transfer.
  always_comb begin
    fault_d = fault_q;
    for (int k = 0; k < N; k++) begin
      cnt_d[k] = cnt_q[k];
    end
    if (clr_fault) begin
      fault_d = '0;
      for (int k = 0; k < N; k++) begin
        cnt_d[k] = '0;
      end
    end else if (xfer) begin
      for (int k = 0; k < N; k++) begin
        if (active[k]) begin
          if (diff[k]) begin
            if (cnt_q[k] != 4'hF) begin
              cnt_d[k] = cnt_q[k] + 4'd1;
            end
            if (cnt_d[k] >= 4'(FAULT_LIM)) begin
              fault_d[k] = 1'b1;
            end
          end else begin
            cnt_d[k] = '0;
          end
        end
      end
    end
  end

  // State registers; the async reset drops a held result without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      disagree_q  <= '0;
      no_quorum_q <= 1'b0;
      fault_q     <= '0;
      for (int k = 0; k < N; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      disagree_q  <= disagree_d;
      no_quorum_q <= no_quorum_d;
      fault_q     <= fault_d;
      for (int k = 0; k < N; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

endmodule

// File: tb/tb_seq_majority_voter.sv
// Testbench for seq_majority_voter (N=9, W=16, FAULT_LIM=4).
// It keeps a reference model of the vote and fault state.
// Expected results go into a scoreboard queue when a transfer is driven.
// Each entry is popped and compared when the DUT presents the result.
module tb_seq_majority_voter;

  localparam int N  = 9;
  localparam int W  = 16;
  localparam int FL = 4;

  typedef struct {
    logic [W-1:0] y;
    logic [N-1:0] dis;
    logic         nq;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_bus;
  logic [N-1:0]   chan_en;
  logic           clr_fault;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   y;
  logic [N-1:0]   disagree;
  logic [N-1:0]   fault;
  logic           no_quorum;

  logic [W-1:0]   chan [N];
  exp_t           sb [$];
  int             m_cnt [N];
  logic [N-1:0]   m_fault;
  logic           m_ov;
  logic [W-1:0]   last_y;
  int             checks;
  int             errors;

  seq_majority_voter #(.N(N), .W(W), .FAULT_LIM(FL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bus    (in_bus),
    .chan_en   (chan_en),
    .clr_fault (clr_fault),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .disagree  (disagree),
    .fault     (fault),
    .no_quorum (no_quorum)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference vote: a bit is 1 when twice its ones-count exceeds the active count.
  function automatic exp_t modelVote(input logic [N-1:0] act);
    exp_t e;
    int   a;
    int   ones;
    a = $countones(act);
    e.y = '0;
    for (int i = 0; i < W; i++) begin
      ones = 0;
      for (int k = 0; k < N; k++) begin
        if (act[k] && chan[k][i]) ones++;
      end
      e.y[i] = (2 * ones > a);
    end
    for (int k = 0; k < N; k++) begin
      e.dis[k] = act[k] && (chan[k] != e.y);
    end
    e.nq = (a == 0);
    return e;
  endfunction

  task automatic resetModel();
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
    m_fault = '0;
    m_ov    = 1'b0;
    sb.delete();
  endtask

  // Drive one cycle of stimulus, advance the model, then check the DUT after the edge.
  task automatic applyStimulus(input logic vld, input logic [N-1:0] en, input logic clr, input logic ordy);
    logic         exp_ready;
    logic         xfer;
    logic [N-1:0] act;
    exp_t         e;
    @(negedge clk);
    in_valid  = vld;
    chan_en   = en;
    clr_fault = clr;
    out_ready = ordy;
    for (int k = 0; k < N; k++) in_bus[k*W +: W] = chan[k];
    #1;
    exp_ready = !m_ov || ordy;
    checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
    xfer = vld && exp_ready;
    act  = en & ~m_fault;
    e    = modelVote(act);
    if (xfer) sb.push_back(e);
    if (clr) begin
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
      m_fault = '0;
    end else if (xfer) begin
      for (int k = 0; k < N; k++) begin
        if (act[k]) begin
          if (e.dis[k]) begin
            m_cnt[k] = (m_cnt[k] < 15) ? m_cnt[k] + 1 : 15;
            if (m_cnt[k] >= FL) m_fault[k] = 1'b1;
          end else begin
            m_cnt[k] = 0;
          end
        end
      end
    end
    if (xfer) m_ov = 1'b1;
    else if (ordy) m_ov = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("out_valid", 32'(out_valid), 32'(m_ov));
    if (xfer) begin
      if (sb.size() == 0) begin
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        checkOutput("y", 32'(y), 32'(e.y));
        checkOutput("disagree", 32'(disagree), 32'(e.dis));
        checkOutput("no_quorum", 32'(no_quorum), 32'(e.nq));
        last_y = e.y;
      end
    end else if (m_ov) begin
      checkOutput("y_held", 32'(y), 32'(last_y));
    end
    checkOutput("fault", 32'(fault), 32'(m_fault));
  endtask

  task automatic setChans(input logic [W-1:0] base, input int idx, input logic [W-1:0] val);
    for (int k = 0; k < N; k++) chan[k] = base;
    if (idx >= 0 && idx < N) chan[idx] = val;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    last_y    = '0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    chan_en   = '1;
    clr_fault = 1'b0;
    out_ready = 1'b1;
    in_bus    = '0;
    setChans(16'h0000, -1, 16'h0000);
    resetModel();

    // Reset state while rst_n is held low.
    #12;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_y", 32'(y), 32'd0);
    checkOutput("rst_disagree", 32'(disagree), 32'd0);
    checkOutput("rst_no_quorum", 32'(no_quorum), 32'd0);
    checkOutput("rst_fault", 32'(fault), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 5-4 split, all enabled.
    for (int k = 0; k < N; k++) chan[k] = (k < 5) ? 16'hFFFF : 16'h0000;
    applyStimulus(1'b1, 9'h1FF, 1'b0, 1'b1);
    checkOutput("v031_y", 32'(y), 32'h0000FFFF);
    checkOutput("v031_dis", 32'(disagree), 32'h000001E0);

    // Channel 3 keeps disagreeing and trips its fault on the 4th transfer.
    setChans(16'h0000, 3, 16'h0001);
    for (int t = 0; t < 4; t++) applyStimulus(1'b1, 9'h1FF, 1'b0, 1'b1);
    checkOutput("v032_fault3", 32'(fault), 32'h00000008);
    applyStimulus(1'b1, 9'h1FF, 1'b0, 1'b1);
    checkOutput("v032_dis3", 32'(disagree[3]), 32'd0);

    // Clear coinciding with a transfer: vote still excludes channel 3.
    setChans(16'h0000, 3, 16'hFFFF);
    applyStimulus(1'b1, 9'h1FF, 1'b1, 1'b1);
    checkOutput("v036_dis", 32'(disagree), 32'd0);
    checkOutput("v036_fault", 32'(fault), 32'd0);

    // 2-2 tie among four enabled channels.
    setChans(16'h0000, -1, 16'h0000);
    chan[0] = 16'hAAAA; chan[1] = 16'hAAAA; chan[2] = 16'h5555; chan[3] = 16'h5555;
    applyStimulus(1'b1, 9'h00F, 1'b0, 1'b1);
    checkOutput("v033_y", 32'(y), 32'd0);
    checkOutput("v033_dis", 32'(disagree), 32'h0000000F);

    // No channels enabled.
    applyStimulus(1'b1, 9'h000, 1'b0, 1'b1);
    checkOutput("v034_nq", 32'(no_quorum), 32'd1);
    checkOutput("v034_y", 32'(y), 32'd0);

    // Backpressure: load, stall three cycles, then drain and reload together.
    setChans(16'h1234, 7, 16'hFFFF);
    applyStimulus(1'b1, 9'h1FF, 1'b0, 1'b0);
    setChans(16'h4321, -1, 16'h0000);
    for (int t = 0; t < 3; t++) applyStimulus(1'b1, 9'h1FF, 1'b0, 1'b0);
    applyStimulus(1'b1, 9'h1FF, 1'b0, 1'b1);
    checkOutput("v035_y", 32'(y), 32'h00004321);
    applyStimulus(1'b0, 9'h1FF, 1'b0, 1'b1);

    // Randomised traffic mixing small symbol sets to provoke disagreement and faults.
    for (int t = 0; t < 60; t++) begin
      for (int k = 0; k < N; k++) begin
        chan[k] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hC3A5;
      end
      applyStimulus(1'($urandom_range(0, 3) != 0), 9'($urandom) | 9'h010,
                    1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
    end

    // Reset asserted while a result is held must drop out_valid at once.
    applyStimulus(1'b1, 9'h1FF, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_fault", 32'(fault), 32'd0);
    resetModel();
    @(negedge clk);
    rst_n = 1'b1;
    setChans(16'h00FF, 0, 16'hFF00);
    applyStimulus(1'b1, 9'h1FF, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
